cm_acq_cmd_engine: RTL and testbench
====================================

CM_ACQ_CMD_ENGINE -- requirements
Module: cm_acq_cmd_engine

Interface
REQ-001 Parameter ADDR_W, default 24, flash address width in bits; SHALL be a multiple of 8.
REQ-002 Parameter LEN_W, default 16, transfer length width in bits; SHALL be a multiple of 8.
REQ-003 Parameter FIFO_DEPTH, default 16, read-data buffer depth in bytes; SHALL be a power of 2 and at least 2.
REQ-004 Parameter TIMEOUT_CYC, default 50000, maximum number of clk cycles allowed between packet bytes.
REQ-005 Port clk, input, 1, single clock; reset is synchronous and active-high.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Ports rx_int (input, 1) and rx_data (input, 8) carry the UART received byte; rx_int is a 1-cycle valid strobe.
REQ-008 Ports flash_req (output, 1), flash_cmd (output, 8), flash_addr (output, ADDR_W) and flash_len (output, LEN_W) form the flash request.
REQ-009 Port flash_ack, input, 1, flash controller accepts the request.
REQ-010 Ports flash_rd_data (input, 8), flash_rd_valid (input, 1) and flash_rd_ready (output, 1) carry flash read bytes.
REQ-011 Port flash_done, input, 1, 1-cycle pulse marking the end of the flash operation.
REQ-012 Ports tx_data (output, 8), tx_valid (output, 1) and tx_ready (input, 1) drive the UART transmitter.
REQ-013 Ports busy (output, 1), err_cksum (output, 1) and err_timeout (output, 1) report status; both error outputs are 1-cycle pulses.

Function
REQ-014 Packet format, all fields MSB-first: 0xA5, then cmd, then ADDR_W/8 address bytes, then LEN_W/8 length bytes, then the checksum byte when CHECKSUM_EN is defined.
REQ-015 FSM states: IDLE, CMD, ADDR, LEN, CKS, ISSUE, XFER.
REQ-016 A byte is consumed only on a cycle where rx_int=1.
REQ-017 In IDLE, 0xA5 SHALL advance the FSM to CMD; any other byte SHALL be ignored.
REQ-018 CMD, ADDR and LEN each shift in their bytes, using a byte counter to track position within the field.
REQ-019 After the last LEN byte, the FSM SHALL go to CKS if CHECKSUM_EN is defined, and to ISSUE otherwise.
REQ-020 flash_req SHALL assert the cycle after the final packet byte and hold, with cmd/addr/len stable, until the cycle flash_ack=1.
REQ-021 After flash_ack the FSM SHALL move to XFER.
REQ-022 If the length field is 0, the FSM SHALL return to IDLE without asserting flash_req.
REQ-023 In CMD, ADDR, LEN and CKS, an inter-byte gap of TIMEOUT_CYC cycles SHALL pulse err_timeout and return the FSM to IDLE with the partial packet discarded.
REQ-024 rx bytes received in ISSUE or XFER SHALL be ignored.
REQ-025 FIFO behaviour: flash_rd_ready = !full; a byte is pushed on flash_rd_valid && flash_rd_ready; flash_rd_valid while full is not accepted.
REQ-026 UART side: tx_valid = !empty, tx_data = FIFO head, and a byte is popped on tx_valid && tx_ready.
REQ-027 A simultaneous push and pop SHALL leave the occupancy count unchanged; read and write pointers wrap modulo FIFO_DEPTH.
REQ-028 XFER SHALL exit to IDLE when flash_done has been seen (latched) and the FIFO is empty.
REQ-029 flash_done and FIFO-empty occurring in the same cycle SHALL be treated as exit-ready.
REQ-030 busy = 1 in every state other than IDLE.
REQ-031 Data latency: first tx_valid SHALL assert the cycle after the first pushed byte; FIFO throughput is 1 byte/cycle.

Reset
REQ-032 On rst=1 at a clk edge the block SHALL go to IDLE, clear the FIFO pointers and count, and clear all latches.
REQ-033 Output reset values: flash_req=0, flash_cmd=0, flash_addr=0, flash_len=0, tx_valid=0, flash_rd_ready=1, busy=0, err_cksum=0, err_timeout=0.
REQ-034 Reset asserted mid-transfer SHALL discard all buffered data; a subsequent flash_done SHALL be ignored.

Configuration
REQ-035 Macro CM_ACQ_CHECKSUM_EN, when defined: the CKS state is present and the checksum byte must equal the XOR of cmd, address and length bytes.
REQ-036 With CM_ACQ_CHECKSUM_EN defined, a checksum mismatch SHALL pulse err_cksum and return the FSM to IDLE without asserting flash_req.
REQ-037 With CM_ACQ_CHECKSUM_EN not defined: no CKS state, err_cksum is tied to 0, and the packet is one byte shorter.

Verification
REQ-038 Packet A5 03 00 10 00 00 04 (+ checksum 0x17 if enabled) -> flash_req with cmd=0x03, addr=0x001000, len=4; ack; 4 bytes pushed -> same 4 bytes appear on tx in order; busy falls after the last pop.
REQ-039 tx_ready held 0, 20 bytes offered by flash -> flash_rd_ready=0 after 16 bytes accepted; release tx_ready -> all 20 bytes delivered in order with no loss.
REQ-040 Gap of TIMEOUT_CYC cycles after the ADDR bytes -> one err_timeout pulse, FSM returns to IDLE, no flash_req; the next valid packet is processed normally.
REQ-041 CHECKSUM_EN defined and checksum 0x00 sent for the A5 03 packet -> one err_cksum pulse, no flash_req.
REQ-042 len=0 packet -> no flash_req, busy deasserts within 2 cycles; rst asserted mid-XFER -> all outputs take their reset values next cycle.

Source files
------------

// File: rtl/cm_acq_cmd_engine.sv
// rtl/cm_acq_cmd_engine.sv - UART command packet parser driving a flash read request and a read-data FIFO to UART tx
// Optional checksum byte/CKS state enabled by defining CM_ACQ_CHECKSUM_EN.
module cm_acq_cmd_engine #(
  parameter int ADDR_W      = 24,
  parameter int LEN_W       = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_int,
  input  logic [7:0]        rx_data,
  output logic              flash_req,
  output logic [7:0]        flash_cmd,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [LEN_W-1:0]  flash_len,
  input  logic              flash_ack,
  input  logic [7:0]        flash_rd_data,
  input  logic              flash_rd_valid,
  output logic              flash_rd_ready,
  input  logic              flash_done,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              err_cksum,
  output logic              err_timeout
);

  localparam int ADDR_BYTES = ADDR_W / 8;
  localparam int LEN_BYTES  = LEN_W / 8;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int TMR_W      = $clog2(TIMEOUT_CYC + 1);
  localparam int BC_W       = 8;

`ifdef CM_ACQ_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, LEN, CKS, ISSUE, XFER} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, LEN, ISSUE, XFER} state_t;
`endif

  state_t              state_q, state_d;
  logic [BC_W-1:0]     bcnt_q, bcnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                done_seen_q, done_seen_d;
  logic                err_to_q, err_to_d;
`ifdef CM_ACQ_CHECKSUM_EN
  logic [7:0]          cks_q, cks_d;
  logic                err_ck_q, err_ck_d;
`endif

  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full, empty, push, pop;
  logic                rx_phase;
  logic [ADDR_W-1:0]   addr_shift;
  logic [LEN_W-1:0]    len_shift;

  assign full           = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty          = (count_q == '0);
  assign push           = flash_rd_valid && !full;
  assign pop            = !empty && tx_ready;
  assign flash_rd_ready = !full;
  assign tx_valid       = !empty;
  assign tx_data        = mem_q[rd_ptr_q];

  assign flash_req   = (state_q == ISSUE);
  assign flash_cmd   = cmd_q;
  assign flash_addr  = addr_q;
  assign flash_len   = len_q;
  assign busy        = (state_q != IDLE);
  assign err_timeout = err_to_q;
`ifdef CM_ACQ_CHECKSUM_EN
  assign err_cksum   = err_ck_q;
  assign rx_phase    = (state_q == CMD) || (state_q == ADDR) || (state_q == LEN) || (state_q == CKS);
`else
  assign err_cksum   = 1'b0;
  assign rx_phase    = (state_q == CMD) || (state_q == ADDR) || (state_q == LEN);
`endif

  assign addr_shift = ADDR_W'({addr_q, rx_data});
  assign len_shift  = LEN_W'({len_q, rx_data});

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    tmr_d       = tmr_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    len_d       = len_q;
    done_seen_d = done_seen_q;
    err_to_d    = 1'b0;
`ifdef CM_ACQ_CHECKSUM_EN
    cks_d       = cks_q;
    err_ck_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        bcnt_d      = '0;
        tmr_d       = '0;
        done_seen_d = 1'b0;
`ifdef CM_ACQ_CHECKSUM_EN
        cks_d       = '0;
`endif
        if (rx_int && rx_data == 8'hA5) state_d = CMD;
      end
      CMD: begin
        if (rx_int) begin
          cmd_d   = rx_data;
          bcnt_d  = '0;
          state_d = ADDR;
`ifdef CM_ACQ_CHECKSUM_EN
          cks_d   = cks_q ^ rx_data;
`endif
        end
      end
      ADDR: begin
        if (rx_int) begin
          addr_d = addr_shift;
          bcnt_d = bcnt_q + 1'b1;
`ifdef CM_ACQ_CHECKSUM_EN
          cks_d  = cks_q ^ rx_data;
`endif
          if (bcnt_q == BC_W'(ADDR_BYTES - 1)) begin
            bcnt_d  = '0;
            state_d = LEN;
          end
        end
      end
      LEN: begin
        if (rx_int) begin
          len_d  = len_shift;
          bcnt_d = bcnt_q + 1'b1;
`ifdef CM_ACQ_CHECKSUM_EN
          cks_d  = cks_q ^ rx_data;
`endif
          if (bcnt_q == BC_W'(LEN_BYTES - 1)) begin
            bcnt_d  = '0;
`ifdef CM_ACQ_CHECKSUM_EN
            state_d = CKS;
`else
            state_d = (len_shift == '0) ? IDLE : ISSUE;
`endif
          end
        end
      end
`ifdef CM_ACQ_CHECKSUM_EN
      CKS: begin
        if (rx_int) begin
          if (rx_data != cks_q) begin
            err_ck_d = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d = (len_q == '0) ? IDLE : ISSUE;
          end
        end
      end
`endif
      ISSUE: begin
        done_seen_d = 1'b0;
        if (flash_ack) state_d = XFER;
      end
      XFER: begin
        if (flash_done) done_seen_d = 1'b1;
        // A done pulse coincident with an empty FIFO exits immediately.
        if ((done_seen_q || flash_done) && empty && !push) begin
          done_seen_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_phase) begin
      if (rx_int) begin
        tmr_d = '0;
      end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
        tmr_d    = '0;
        err_to_d = 1'b1;
        state_d  = IDLE;
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end

    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      tmr_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      done_seen_q <= 1'b0;
      err_to_q    <= 1'b0;
`ifdef CM_ACQ_CHECKSUM_EN
      cks_q       <= '0;
      err_ck_q    <= 1'b0;
`endif
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      tmr_q       <= tmr_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      done_seen_q <= done_seen_d;
      err_to_q    <= err_to_d;
`ifdef CM_ACQ_CHECKSUM_EN
      cks_q       <= cks_d;
      err_ck_q    <= err_ck_d;
`endif
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flash_rd_data;
  end

endmodule

// File: tb/tb_cm_acq_cmd_engine.sv
// tb/tb_cm_acq_cmd_engine.sv - directed table-driven bench for cm_acq_cmd_engine
module tb_cm_acq_cmd_engine;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst, rx_int, flash_ack, flash_rd_valid, flash_done, tx_ready;
  logic [7:0]  rx_data, flash_rd_data;
  logic        flash_req, flash_rd_ready, tx_valid, busy, err_cksum, err_timeout;
  logic [7:0]  flash_cmd, tx_data;
  logic [23:0] flash_addr;
  logic [15:0] flash_len;

  int checks = 0;
  int errors = 0;
  int to_pulses = 0;
  int req_cycles = 0;

  always #5 clk = ~clk;

  cm_acq_cmd_engine #(.ADDR_W(24), .LEN_W(16), .FIFO_DEPTH(16), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_int(rx_int), .rx_data(rx_data),
    .flash_req(flash_req), .flash_cmd(flash_cmd), .flash_addr(flash_addr), .flash_len(flash_len),
    .flash_ack(flash_ack), .flash_rd_data(flash_rd_data), .flash_rd_valid(flash_rd_valid),
    .flash_rd_ready(flash_rd_ready), .flash_done(flash_done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .err_cksum(err_cksum), .err_timeout(err_timeout)
  );

  always @(posedge clk) begin
    if (err_timeout) to_pulses++;
    if (flash_req) req_cycles++;
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    logic [15:0] len;
    logic        exp_req;
  } pkt_t;

  pkt_t vec [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_int  = 1'b1;
    rx_data = b;
    tick();
    rx_int  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [23:0] addr, input logic [15:0] len,
                          input logic [7:0] cks);
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(addr[23:16]);
    send_byte(addr[15:8]);
    send_byte(addr[7:0]);
    send_byte(len[15:8]);
`ifdef CM_ACQ_CHECKSUM_EN
    send_byte(len[7:0]);
    send_byte(cks);
`else
    send_byte(len[7:0] ^ (cks & 8'h00));
`endif
  endtask

  function automatic logic [7:0] xsum(input logic [7:0] cmd, input logic [23:0] a, input logic [15:0] l);
    return cmd ^ a[23:16] ^ a[15:8] ^ a[7:0] ^ l[15:8] ^ l[7:0];
  endfunction

  task automatic run_pkt(input pkt_t p);
    int got, bad;
    logic [7:0] exp_b;
    send_pkt(p.cmd, p.addr, p.len, xsum(p.cmd, p.addr, p.len));
    chk("req_after_pkt", flash_req, p.exp_req);
    if (p.exp_req) begin
      chk("flash_cmd", flash_cmd, p.cmd);
      chk("flash_addr", flash_addr, p.addr);
      chk("flash_len", flash_len, p.len);
      tick();
      chk("req_held", flash_req, 1'b1);
      flash_ack = 1'b1;
      tick();
      flash_ack = 1'b0;
      chk("req_drop_after_ack", flash_req, 1'b0);
      for (int i = 0; i < int'(p.len); i++) begin
        flash_rd_valid = 1'b1;
        flash_rd_data  = 8'(p.cmd + 8'(i) * 8'h11);
        tick();
        if (i == 0) chk("tx_valid_latency", tx_valid, 1'b1);
      end
      flash_rd_valid = 1'b0;
      flash_done = 1'b1;
      tick();
      flash_done = 1'b0;
      chk("busy_while_buffered", busy, 1'b1);
      tx_ready = 1'b1;
      got = 0;
      bad = 0;
      for (int c = 0; c < 100 && got < int'(p.len); c++) begin
        if (tx_valid) begin
          exp_b = 8'(p.cmd + 8'(got) * 8'h11);
          if (tx_data !== exp_b) bad++;
          got++;
        end
        tick();
      end
      tx_ready = 1'b0;
      chk("tx_count", got, p.len);
      chk("tx_data_order", bad, 0);
      for (int c = 0; c < 3 && busy; c++) tick();
      chk("busy_fall", busy, 1'b0);
    end else begin
      for (int c = 0; c < 2 && busy; c++) tick();
      chk("busy_len0", busy, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, got, bad, to0, rq0;
    logic ok;

    vec[0] = '{cmd: 8'h03, addr: 24'h001000, len: 16'd4, exp_req: 1'b1};
    vec[1] = '{cmd: 8'h0B, addr: 24'hABCDEF, len: 16'd1, exp_req: 1'b1};
    vec[2] = '{cmd: 8'hFF, addr: 24'h000000, len: 16'd2, exp_req: 1'b1};
    vec[3] = '{cmd: 8'h00, addr: 24'hFFFFFF, len: 16'd0, exp_req: 1'b0};

    rst = 1'b1; rx_int = 1'b0; rx_data = '0; flash_ack = 1'b0; flash_rd_valid = 1'b0;
    flash_rd_data = '0; flash_done = 1'b0; tx_ready = 1'b0;
    tick(); tick();
    chk("rst_flash_req", flash_req, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_rd_ready", flash_rd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_addr_len", {flash_cmd, flash_addr}, 32'h0);
    chk("rst_errs", {err_cksum, err_timeout}, 2'b00);
    rst = 1'b0;
    tick();

    send_byte(8'h5A);
    send_byte(8'h00);
    chk("idle_ignores_noise", busy, 1'b0);

    for (int v = 0; v < 4; v++) run_pkt(vec[v]);

    // FIFO fill with a stalled transmitter, then drain
    send_pkt(8'h03, 24'h002000, 16'd20, xsum(8'h03, 24'h002000, 16'd20));
    chk("fill_req", flash_req, 1'b1);
    send_byte(8'hA5);
    chk("issue_ignores_rx", {flash_req, flash_cmd}, {1'b1, 8'h03});
    flash_ack = 1'b1; tick(); flash_ack = 1'b0;
    acc = 0;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      flash_rd_valid = 1'b1;
      flash_rd_data  = 8'(acc);
      ok = flash_rd_ready;
      tick();
      if (ok) acc++;
    end
    chk("fill_accepted", acc, 16);
    chk("full_rd_ready", flash_rd_ready, 1'b0);
    flash_rd_data = 8'(acc);
    repeat (3) tick();
    chk("full_hold_rd_ready", flash_rd_ready, 1'b0);
    tx_ready = 1'b1;
    got = 0; bad = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      if (tx_valid) begin
        if (tx_data !== 8'(got)) bad++;
        got++;
      end
      if (acc < 20) begin
        flash_rd_valid = 1'b1;
        flash_rd_data  = 8'(acc);
        ok = flash_rd_ready;
      end else begin
        flash_rd_valid = 1'b0;
        ok = 1'b0;
      end
      tick();
      if (ok) acc++;
    end
    flash_rd_valid = 1'b0;
    chk("drain_count", got, 20);
    chk("drain_order", bad, 0);
    chk("drain_busy_before_done", busy, 1'b1);
    flash_done = 1'b1; tick(); flash_done = 1'b0;
    tx_ready = 1'b0;
    chk("done_and_empty_exit", busy, 1'b0);

    // inter-byte timeout after the address bytes
    to0 = to_pulses; rq0 = req_cycles;
    send_byte(8'hA5); send_byte(8'h03);
    send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    repeat (TMO - 1) tick();
    chk("tmo_not_yet", {busy, err_timeout}, 2'b10);
    tick();
    chk("tmo_fire", {busy, err_timeout}, 2'b01);
    tick();
    chk("tmo_single_pulse", to_pulses - to0, 1);
    chk("tmo_no_req", req_cycles - rq0, 0);
    run_pkt(vec[0]);

`ifdef CM_ACQ_CHECKSUM_EN
    rq0 = req_cycles;
    send_pkt(8'h03, 24'h001000, 16'd4, 8'h00);
    chk("cks_err_pulse", {err_cksum, busy, flash_req}, 3'b100);
    tick();
    chk("cks_err_clear", err_cksum, 1'b0);
    chk("cks_no_req", req_cycles - rq0, 0);
`endif

    // reset in the middle of a transfer
    send_pkt(8'h07, 24'h123456, 16'd4, xsum(8'h07, 24'h123456, 16'd4));
    flash_ack = 1'b1; tick(); flash_ack = 1'b0;
    flash_rd_valid = 1'b1; flash_rd_data = 8'h99; tick(); tick();
    flash_rd_valid = 1'b0;
    chk("pre_rst_xfer", {busy, tx_valid}, 2'b11);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_outputs", {flash_req, tx_valid, flash_rd_ready, busy, err_cksum, err_timeout}, 6'b001000);
    chk("midrst_fields", {flash_cmd, flash_addr}, 32'h0);
    chk("midrst_len", flash_len, 16'h0);
    flash_done = 1'b1; tick(); flash_done = 1'b0;
    tick();
    chk("post_rst_done_ignored", {busy, tx_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
